cpu_run_ctrl: RTL and testbench

- Parametrised execution controller for the CPU on the DE2 test top.
- Debounces the board push-buttons and sequences a one-cycle clock-enable to the CPU.
- Modes: halt, single-step, free-run at a divided rate, stop on a PC breakpoint.
- Counts executed instructions; the count feeds the LCD/7-seg debug displays.

---
 rtl/cpu_run_pkg.sv | 18 +
 rtl/key_debounce.sv | 69 ++++++
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and default timing constants for the CPU run controller.
package cpu_run_pkg;

  // Controller states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BREAK = 2'd3
  } run_state_t;

  // 10 ms of key stability at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  // 10 instructions per second at 50 MHz.
  localparam int unsigned DEFAULT_RUN_DIV = 5000000;

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF synchroniser, stability counter and a
// single-cycle press pulse on the accepted released->pressed transition.
module key_debounce
  import cpu_run_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic iRST_N,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Bring the raw asynchronous key into the clk domain; idle level is released.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the current one for a full run of cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level, stability counter and press pulse registers.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the DE2 test CPU: halt, single-step, divided-rate
// free run and PC breakpoint, with a saturating executed-instruction counter.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = 8,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEFAULT_RUN_DIV
) (
  input  logic                 clk,
  input  logic                 iRST_N,
  input  logic                 key_step_n,
  input  logic                 key_run_n,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic                 at_bp,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0]        DIV_LAST = DW'(RUN_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  run_state_t           state_q;
  run_state_t           state_d;
  logic [DW-1:0]        div_q;
  logic [DW-1:0]        div_d;
  logic                 resume_q;
  logic                 resume_d;
  logic                 at_bp_q;
  logic                 at_bp_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic                 step_press;
  logic                 run_press;
  logic                 tick;
  logic                 bp_hit;
  logic                 en;
  logic [1:0]           unused_levels;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk   (clk),
    .iRST_N(iRST_N),
    .key_n (key_step_n),
    .level (unused_levels[0]),
    .press (step_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk   (clk),
    .iRST_N(iRST_N),
    .key_n (key_run_n),
    .level (unused_levels[1]),
    .press (run_press)
  );

  // The resume flag lets the first enable after a break execute the trapped instruction.
  assign tick   = (state_q == RUN) && (div_q == DIV_LAST);
  assign bp_hit = bp_en && (pc == bp_addr) && !resume_q;

  // Next-state decode; cpu_en is decoded here from registered state and the divider tick.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    resume_d = resume_q;
    at_bp_d  = at_bp_q;
    en       = 1'b0;
    case (state_q)
      HALT: begin
        if (run_press) begin
          state_d = RUN;
          div_d   = '0;
        end else if (step_press) begin
          state_d = STEP;
        end
      end
      STEP: begin
        en      = 1'b1;
        state_d = HALT;
      end
      RUN: begin
        if (run_press) begin
          state_d = HALT;
          div_d   = '0;
        end else if (tick) begin
          div_d = '0;
          if (bp_hit) begin
            state_d = BREAK;
            at_bp_d = 1'b1;
          end else begin
            en       = 1'b1;
            resume_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      BREAK: begin
        if (run_press || step_press) begin
          state_d  = run_press ? RUN : STEP;
          at_bp_d  = 1'b0;
          resume_d = 1'b1;
          div_d    = '0;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Instruction counter holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= HALT;
      div_q    <= '0;
      resume_q <= 1'b0;
      at_bp_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      resume_q <= resume_d;
      at_bp_q  <= at_bp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_en    = en;
  assign state     = state_q;
  assign at_bp     = at_bp_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with short debounce and run-rate settings.
// Cycle index i is the clock period starting at posedge i; outputs are sampled at negedge i.
module tb_cpu_run_ctrl;

  logic       clk = 1'b0;
  logic       iRST_N;
  logic       key_step_n;
  logic       key_run_n;
  logic       bp_en;
  logic [7:0] bp_addr;
  logic [7:0] pc;
  logic       pcClear;
  logic       cpu_en;
  logic [1:0] state;
  logic       at_bp;
  logic [3:0] instr_cnt;

  int checks   = 0;
  int failures = 0;

  cpu_run_ctrl #(
    .PC_WIDTH       (8),
    .CNT_WIDTH      (4),
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (3)
  ) dut (
    .clk       (clk),
    .iRST_N    (iRST_N),
    .key_step_n(key_step_n),
    .key_run_n (key_run_n),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_en    (cpu_en),
    .state     (state),
    .at_bp     (at_bp),
    .instr_cnt (instr_cnt)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Minimal CPU model: the program counter advances on every enabled clock.
  always @(posedge clk) begin
    if (pcClear) pc <= 8'd0;
    else if (cpu_en) pc <= pc + 8'd1;
  end

  task automatic resetDut();
    iRST_N     = 1'b0;
    key_step_n = 1'b1;
    key_run_n  = 1'b1;
    bp_en      = 1'b0;
    bp_addr    = 8'd0;
    pcClear    = 1'b1;
    repeat (3) @(negedge clk);
    pcClear = 1'b0;
    iRST_N  = 1'b1;
  endtask

  task automatic test_reset();
    resetDut();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== 2'd0 || cpu_en !== 1'b0 || at_bp !== 1'b0 || instr_cnt !== 4'd0) begin
        failures++;
        $display("[TB] FAIL reset i=%0d got state=%0d en=%0b bp=%0b cnt=%0d exp 0/0/0/0",
                 i, state, cpu_en, at_bp, instr_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_step();
    resetDut();
    key_step_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_en !== (i == 7)) begin
        failures++;
        $display("[TB] FAIL step_en i=%0d got=%0b exp=%0b", i, cpu_en, (i == 7));
      end
      checks++;
      if (state !== ((i == 7) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("[TB] FAIL step_state i=%0d got=%0d exp=%0d", i, state, (i == 7) ? 1 : 0);
      end
      checks++;
      if (instr_cnt !== ((i >= 8) ? 4'd1 : 4'd0)) begin
        failures++;
        $display("[TB] FAIL step_cnt i=%0d got=%0d exp=%0d", i, instr_cnt, (i >= 8) ? 1 : 0);
      end
      if (i == 10) key_step_n = 1'b1;
    end
  endtask

  task automatic test_glitch();
    resetDut();
    key_run_n = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_en !== 1'b0 || state !== 2'd0) begin
        failures++;
        $display("[TB] FAIL glitch i=%0d got en=%0b state=%0d exp en=0 state=0", i, cpu_en, state);
      end
      if (i == 3) key_run_n = 1'b1;
    end
  endtask

  task automatic test_run();
    logic [7:0] expPc;
    logic [3:0] expCnt;
    logic       expEn;
    logic [1:0] expState;
    resetDut();
    expPc     = 8'd0;
    expCnt    = 4'd0;
    key_run_n = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      expEn    = (i >= 9) && (i <= 75) && ((i - 9) % 3 == 0);
      expState = (i < 7) ? 2'd0 : (i <= 76) ? 2'd2 : 2'd0;
      checks++;
      if (cpu_en !== expEn) begin
        failures++;
        $display("[TB] FAIL run_en i=%0d got=%0b exp=%0b", i, cpu_en, expEn);
      end
      checks++;
      if (state !== expState) begin
        failures++;
        $display("[TB] FAIL run_state i=%0d got=%0d exp=%0d", i, state, expState);
      end
      checks++;
      if (instr_cnt !== expCnt) begin
        failures++;
        $display("[TB] FAIL run_cnt i=%0d got=%0d exp=%0d", i, instr_cnt, expCnt);
      end
      checks++;
      if (pc !== expPc) begin
        failures++;
        $display("[TB] FAIL run_pc i=%0d got=%0d exp=%0d", i, pc, expPc);
      end
      if (expEn) begin
        expPc = expPc + 8'd1;
        if (expCnt != 4'd15) expCnt = expCnt + 4'd1;
      end
      if (i == 10) key_run_n = 1'b1;
      if (i == 70) key_run_n = 1'b0;
      if (i == 80) key_run_n = 1'b1;
    end
  endtask

  task automatic test_breakpoint();
    logic [7:0] expPc;
    logic       expEn;
    logic [1:0] expState;
    logic       expAtBp;
    resetDut();
    bp_en     = 1'b1;
    bp_addr   = 8'h05;
    expPc     = 8'd0;
    key_run_n = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      expEn    = ((i >= 9) && (i <= 21) && ((i - 9) % 3 == 0)) ||
                 ((i >= 39) && ((i - 39) % 3 == 0));
      expState = (i < 7) ? 2'd0 : (i <= 24) ? 2'd2 : (i <= 36) ? 2'd3 : 2'd2;
      expAtBp  = (i >= 25) && (i <= 36);
      checks++;
      if (cpu_en !== expEn) begin
        failures++;
        $display("[TB] FAIL bp_en i=%0d got=%0b exp=%0b", i, cpu_en, expEn);
      end
      checks++;
      if (state !== expState) begin
        failures++;
        $display("[TB] FAIL bp_state i=%0d got=%0d exp=%0d", i, state, expState);
      end
      checks++;
      if (at_bp !== expAtBp) begin
        failures++;
        $display("[TB] FAIL bp_atbp i=%0d got=%0b exp=%0b", i, at_bp, expAtBp);
      end
      checks++;
      if (pc !== expPc) begin
        failures++;
        $display("[TB] FAIL bp_pc i=%0d got=%0d exp=%0d", i, pc, expPc);
      end
      if (expEn) expPc = expPc + 8'd1;
      if (i == 10) key_run_n = 1'b1;
      if (i == 30) key_run_n = 1'b0;
      if (i == 40) key_run_n = 1'b1;
    end
  endtask

  task automatic test_break_step();
    logic [7:0] expPc;
    logic       expEn;
    logic [1:0] expState;
    logic       expAtBp;
    resetDut();
    bp_en     = 1'b1;
    bp_addr   = 8'h02;
    expPc     = 8'd0;
    key_run_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      expEn    = (i == 9) || (i == 12) || (i == 27);
      expState = (i < 7) ? 2'd0 : (i <= 15) ? 2'd2 : (i <= 26) ? 2'd3 : (i == 27) ? 2'd1 : 2'd0;
      expAtBp  = (i >= 16) && (i <= 26);
      checks++;
      if (cpu_en !== expEn) begin
        failures++;
        $display("[TB] FAIL brkstep_en i=%0d got=%0b exp=%0b", i, cpu_en, expEn);
      end
      checks++;
      if (state !== expState) begin
        failures++;
        $display("[TB] FAIL brkstep_state i=%0d got=%0d exp=%0d", i, state, expState);
      end
      checks++;
      if (at_bp !== expAtBp) begin
        failures++;
        $display("[TB] FAIL brkstep_atbp i=%0d got=%0b exp=%0b", i, at_bp, expAtBp);
      end
      checks++;
      if (pc !== expPc) begin
        failures++;
        $display("[TB] FAIL brkstep_pc i=%0d got=%0d exp=%0d", i, pc, expPc);
      end
      if (expEn) expPc = expPc + 8'd1;
      if (i == 10) key_run_n = 1'b1;
      if (i == 20) key_step_n = 1'b0;
      if (i == 30) key_step_n = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic       expEn;
    logic [1:0] expState;
    resetDut();
    key_step_n = 1'b0;
    key_run_n  = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      expEn    = (i == 9) || (i == 12);
      expState = (i < 7) ? 2'd0 : 2'd2;
      checks++;
      if (state !== expState) begin
        failures++;
        $display("[TB] FAIL both_state i=%0d got=%0d exp=%0d", i, state, expState);
      end
      checks++;
      if (cpu_en !== expEn) begin
        failures++;
        $display("[TB] FAIL both_en i=%0d got=%0b exp=%0b", i, cpu_en, expEn);
      end
      if (i == 10) begin
        key_step_n = 1'b1;
        key_run_n  = 1'b1;
      end
    end
    checks++;
    if (instr_cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL midrun_cnt_before got=%0d exp=1", instr_cnt);
    end
    iRST_N = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || instr_cnt !== 4'd0 || cpu_en !== 1'b0 || at_bp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got state=%0d cnt=%0d en=%0b bp=%0b exp 0/0/0/0",
               state, instr_cnt, cpu_en, at_bp);
    end
    @(negedge clk);
    iRST_N = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 2'd0 || cpu_en !== 1'b0 || instr_cnt !== 4'd0) begin
        failures++;
        $display("[TB] FAIL post_reset i=%0d got state=%0d en=%0b cnt=%0d exp 0/0/0",
                 i, state, cpu_en, instr_cnt);
      end
    end
  endtask

  // Run every scenario in order and report the totals.
  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_run();
    test_breakpoint();
    test_break_step();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
